// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-pass shift sequencer and its
// 8-bit shifter stage.
package shift_sequencer_pkg;

  localparam int DATA_W           = 8;
  localparam int STEP_MAX_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Positions moved by one shifter pass: min(remaining, step_max).
  function automatic int unsigned calc_step(int unsigned rem, int unsigned step_max);
    return (rem < step_max) ? rem : step_max;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bus of the shift sequencer.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both
// high; valid, once raised, holds its payload stable until that edge.
interface shift_sequencer_if
  import shift_sequencer_pkg::*;
#(
  parameter int AMT_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic              in_dir;
  logic              in_rot;
  logic              in_fill;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  state_t            state;

  modport master (
    output in_valid, in_data, in_amt, in_dir, in_rot, in_fill, out_ready,
    input  in_ready, out_valid, out_data, busy, state
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, in_rot, in_fill, out_ready,
    output in_ready, out_valid, out_data, busy, state
  );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// Single 8-bit barrel shifter pass: shift or rotate by s positions, left or right,
// with a fill bit entering vacated positions for plain shifts.
module shift_sequencer_shifter
  import shift_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        s,
  input  logic              en,
  input  logic              d,
  input  logic              r,
  input  logic              f,
  output logic [DATA_W-1:0] y
);

  int src;

  always_comb begin
    y   = din;
    src = 0;
    if (en) begin
      for (int k = 0; k < DATA_W; k++) begin
        src = d ? (k + int'(s)) : (k - int'(s));
        if (src >= 0 && src < DATA_W) begin
          y[k] = din[src];
        end else if (r) begin
          // Out-of-range source wraps around; 3-bit truncation is mod 8.
          y[k] = din[3'(src + DATA_W)];
        end else begin
          y[k] = f;
        end
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: accepts one request, drives the shifter
// for ceil(amt/STEP_MAX) passes, then holds the result until retired.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int AMT_W    = 3,
  parameter int STEP_MAX = STEP_MAX_DEFAULT
)(
  input  logic                 clk,
  input  logic                 rst,
  shift_sequencer_if.slave     bus
);

  state_t            state_q;
  logic [DATA_W-1:0] data_q;
  logic [AMT_W-1:0]  rem_q;
  logic              dir_q;
  logic              rot_q;
  logic              fill_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;

  logic [1:0]        step;
  logic              shf_en;
  logic [DATA_W-1:0] shf_y;

  assign step   = 2'(calc_step(32'(rem_q), STEP_MAX));
  assign shf_en = (state_q == SHIFT);

  // S is forced to zero outside SHIFT so nothing is ever captured from a null pass.
  shift_sequencer_shifter u_shifter (
    .din (data_q),
    .s   (shf_en ? step : 2'd0),
    .en  (shf_en),
    .d   (dir_q),
    .r   (rot_q),
    .f   (fill_q),
    .y   (shf_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      rot_q       <= 1'b0;
      fill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_q <= bus.in_data;
            rem_q  <= bus.in_amt;
            dir_q  <= bus.in_dir;
            rot_q  <= bus.in_rot;
            fill_q <= bus.in_fill;
            busy_q <= 1'b1;
            if (bus.in_amt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= bus.in_data;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= shf_y;
          rem_q  <= rem_q - AMT_W'(step);
          if (rem_q == AMT_W'(step)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= shf_y;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed results and latencies,
// backpressure hold, and asynchronous reset mid-transaction.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic clk;
  logic rst;

  shift_sequencer_if #(.AMT_W(3)) bus ();

  shift_sequencer #(.AMT_W(3), .STEP_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request, wait for the result, check value and latency, retire it.
  task automatic do_req(input string tag, input logic [7:0] data, input logic [2:0] amt,
                        input logic dir, input logic rot, input logic fill,
                        input logic [7:0] exp, input int exp_lat);
    int cycles;
    int wait_cnt;
    logic [7:0] e;
    wait_cnt = 0;
    @(negedge clk);
    while (!bus.in_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_amt   = amt;
    bus.in_dir   = dir;
    bus.in_rot   = rot;
    bus.in_fill  = fill;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cycles = 1;
    while (!bus.out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_data"}, 32'(bus.out_data), 32'(e));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_retired"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_dir    = 1'b0;
    bus.in_rot    = 1'b0;
    bus.in_fill   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // tag, data, amt, dir, rot, fill, expected, latency
    do_req("shl5",    8'hB5, 3'd5, 1'b0, 1'b0, 1'b0, 8'hA0, 3);
    do_req("rotr7",   8'h81, 3'd7, 1'b1, 1'b1, 1'b0, 8'h03, 4);
    do_req("shr4_f1", 8'h0F, 3'd4, 1'b1, 1'b0, 1'b1, 8'hF0, 3);
    do_req("shr4_f0", 8'h0F, 3'd4, 1'b1, 1'b0, 1'b0, 8'h00, 3);
    do_req("amt0",    8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 8'h5A, 1);
    do_req("shl7_f1", 8'h00, 3'd7, 1'b0, 1'b0, 1'b1, 8'h7F, 4);
    do_req("rotr3",   8'h01, 3'd3, 1'b1, 1'b1, 1'b0, 8'h20, 2);
    do_req("rotl6",   8'h96, 3'd6, 1'b0, 1'b1, 1'b0, 8'hA5, 3);

    // Backpressure: result held while the consumer stalls and new requests knock.
    begin
      int cycles;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h3C;
      bus.in_amt   = 3'd1;
      bus.in_dir   = 1'b0;
      bus.in_rot   = 1'b1;
      bus.in_fill  = 1'b0;
      @(posedge clk);
      #1;
      bus.in_data = 8'hFF;
      bus.in_amt  = 3'd0;
      cycles = 1;
      while (!bus.out_valid && cycles < 20) begin
        @(posedge clk);
        #1;
        cycles++;
      end
      check("bp_latency", 32'(cycles), 32'd2);
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        check("bp_out_data", 32'(bus.out_data), 32'h78);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("bp_retired", 32'(bus.out_valid), 32'd0);
      check("bp_no_second_accept", 32'(bus.busy), 32'd0);
    end
    do_req("after_bp", 8'h11, 3'd2, 1'b1, 1'b0, 1'b0, 8'h04, 2);

    // Asynchronous reset after the first pass of a 7-position rotate.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    bus.in_amt   = 3'd7;
    bus.in_dir   = 1'b1;
    bus.in_rot   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    check("mid_out_data_before", 32'(bus.out_data), 32'h04);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_out_data", 32'(bus.out_data), 32'h00);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_state", 32'(bus.state), 32'(IDLE));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_req("post_rst_rotl2", 8'h01, 3'd2, 1'b0, 1'b1, 1'b0, 8'h04, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
